// File: rtl/dmac_ch0_datapath.sv
// Purpose: DMAC channel-0 register file, working address/size/burst counters, 16-entry data buffer, interrupt status.
// Latency: every register/counter effect shows one cycle after the asserting edge; cfg_rdata and m_HWDATA are combinational.
// Backpressure: none -- the master FSM owns sequencing and this block acts on its flags every cycle.
module dmac_ch0_datapath #(
    parameter int DATA_W    = 32,
    parameter int TS_W      = 12,
    parameter int BUF_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic              m_HCLK,
    input  logic              m_HRESETn,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              load_DMAC_C0_Addr,
    input  logic              src_addr_inc,
    input  logic              dest_addr_inc,
    input  logic              TransferSize_dec_flag,
    input  logic              src_burst_zero_flag,
    input  logic              dest_burst_zero_flag,
    input  logic              buffer_zero_flag,
    input  logic              buffer_idx_inc,
    input  logic              load_fir_src_img,
    input  logic              CHANNEL_dis_flag,
    input  logic              set_DMACINTR_status,
    input  logic [DATA_W-1:0] m_HRDATA,
    output logic [DATA_W-1:0] m_HWDATA,
    output logic [DATA_W-1:0] DMAC_C0_SrcAddr_Master,
    output logic [DATA_W-1:0] DMAC_C0_DestAddr_Master,
    output logic [TS_W-1:0]   TS,
    output logic [2:0]        BS,
    output logic              CHANNEL_enable,
    output logic              DMAC_Configuration,
    output logic [4:0]        src_burst_cnt,
    output logic [4:0]        dest_burst_cnt,
    output logic [IDX_W-1:0]  dmac_buffer_idx,
    output logic              DMACINTR_mask,
    output logic              DMACINTR_pend,
    output logic              DMACINTR
);

    localparam logic [2:0] SEL_SRC    = 3'd0;
    localparam logic [2:0] SEL_DEST   = 3'd1;
    localparam logic [2:0] SEL_CTRL   = 3'd2;
    localparam logic [2:0] SEL_CHEN   = 3'd3;
    localparam logic [2:0] SEL_CONFIG = 3'd4;
    localparam logic [2:0] SEL_MASK   = 3'd5;
    localparam logic [2:0] SEL_INTCLR = 3'd6;
    localparam logic [2:0] SEL_STATUS = 3'd7;

    localparam logic [4:0] BURST_MAX = 5'd16;

    logic [DATA_W-1:0] src_prog;
    logic [DATA_W-1:0] dest_prog;
    logic [DATA_W-1:0] data_buf [BUF_DEPTH];

    // Address/size registers are frozen while the channel runs.
    logic prog_open;
    logic wr_src, wr_dest, wr_ctrl, wr_chen, wr_config, wr_mask, wr_intclr;

    assign prog_open = ~CHANNEL_enable;
    assign wr_src    = cfg_we && (cfg_sel == SEL_SRC)  && prog_open;
    assign wr_dest   = cfg_we && (cfg_sel == SEL_DEST) && prog_open;
    assign wr_ctrl   = cfg_we && (cfg_sel == SEL_CTRL) && prog_open;
    assign wr_chen   = cfg_we && (cfg_sel == SEL_CHEN);
    assign wr_config = cfg_we && (cfg_sel == SEL_CONFIG);
    assign wr_mask   = cfg_we && (cfg_sel == SEL_MASK);
    assign wr_intclr = cfg_we && (cfg_sel == SEL_INTCLR) && cfg_wdata[0];

    // Programmed configuration registers written by the CPU.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn) begin
            src_prog           <= '0;
            dest_prog          <= '0;
            BS                 <= '0;
            DMAC_Configuration <= 1'b0;
            DMACINTR_mask      <= 1'b0;
        end else begin
            if (wr_src)    src_prog           <= cfg_wdata;
            if (wr_dest)   dest_prog          <= cfg_wdata;
            if (wr_ctrl)   BS                 <= cfg_wdata[14:12];
            if (wr_config) DMAC_Configuration <= cfg_wdata[0];
            if (wr_mask)   DMACINTR_mask      <= cfg_wdata[0];
        end
    end

    // Channel enable: the FSM's disable beats a simultaneous CPU enable.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn)            CHANNEL_enable <= 1'b0;
        else if (CHANNEL_dis_flag) CHANNEL_enable <= 1'b0;
        else if (wr_chen)          CHANNEL_enable <= cfg_wdata[0];
    end

    // Interrupt status: a new event beats a simultaneous clear so it is never lost.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn)               DMACINTR_pend <= 1'b0;
        else if (set_DMACINTR_status) DMACINTR_pend <= 1'b1;
        else if (wr_intclr)           DMACINTR_pend <= 1'b0;
    end

    assign DMACINTR = DMACINTR_pend & ~DMACINTR_mask;

    // Working addresses: load beats increment; increments wrap at 2^32.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn) begin
            DMAC_C0_SrcAddr_Master  <= '0;
            DMAC_C0_DestAddr_Master <= '0;
        end else if (load_DMAC_C0_Addr) begin
            DMAC_C0_SrcAddr_Master  <= src_prog;
            DMAC_C0_DestAddr_Master <= dest_prog;
        end else begin
            if (src_addr_inc)  DMAC_C0_SrcAddr_Master  <= DMAC_C0_SrcAddr_Master + DATA_W'(4);
            if (dest_addr_inc) DMAC_C0_DestAddr_Master <= DMAC_C0_DestAddr_Master + DATA_W'(4);
        end
    end

    // Remaining size: CTRL write loads it, the FSM counts it down by a word, floor at 0.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn)                 TS <= '0;
        else if (wr_ctrl)               TS <= cfg_wdata[TS_W-1:0];
        else if (TransferSize_dec_flag) TS <= (TS < TS_W'(4)) ? '0 : TS - TS_W'(4);
    end

    // Burst beat counters: zero flag beats increment, count saturates at 16 beats.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn) begin
            src_burst_cnt  <= '0;
            dest_burst_cnt <= '0;
        end else begin
            if (src_burst_zero_flag)                         src_burst_cnt  <= '0;
            else if (src_addr_inc && src_burst_cnt != BURST_MAX)   src_burst_cnt  <= src_burst_cnt + 5'd1;
            if (dest_burst_zero_flag)                        dest_burst_cnt <= '0;
            else if (dest_addr_inc && dest_burst_cnt != BURST_MAX) dest_burst_cnt <= dest_burst_cnt + 5'd1;
        end
    end

    // Buffer index: zero beats increment; natural wrap 15 -> 0.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn)            dmac_buffer_idx <= '0;
        else if (buffer_zero_flag) dmac_buffer_idx <= '0;
        else if (buffer_idx_inc)   dmac_buffer_idx <= dmac_buffer_idx + IDX_W'(1);
    end

    // Buffer storage: captured read data lands at the index current on this edge.
    always_ff @(posedge m_HCLK or negedge m_HRESETn) begin
        if (!m_HRESETn) begin
            for (int i = 0; i < BUF_DEPTH; i++) data_buf[i] <= '0;
        end else if (load_fir_src_img) begin
            data_buf[dmac_buffer_idx] <= m_HRDATA;
        end
    end

    assign m_HWDATA = data_buf[dmac_buffer_idx];

    // CPU readback: programmed addresses, live TS, status snapshot.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_sel)
            SEL_SRC:    cfg_rdata = src_prog;
            SEL_DEST:   cfg_rdata = dest_prog;
            SEL_CTRL:   cfg_rdata = {{(DATA_W-TS_W-3){1'b0}}, BS, TS};
            SEL_CHEN:   cfg_rdata = {{(DATA_W-1){1'b0}}, CHANNEL_enable};
            SEL_CONFIG: cfg_rdata = {{(DATA_W-1){1'b0}}, DMAC_Configuration};
            SEL_MASK:   cfg_rdata = {{(DATA_W-1){1'b0}}, DMACINTR_mask};
            SEL_INTCLR: cfg_rdata = '0;
            SEL_STATUS: cfg_rdata = {{(DATA_W-3){1'b0}}, CHANNEL_enable, DMACINTR, DMACINTR_pend};
            default:    cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmac_ch0_datapath.sv
// Directed bench for the DMAC channel-0 datapath.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Ends with a single summary line.
module tb_dmac_ch0_datapath;

    logic        m_HCLK = 1'b0;
    logic        m_HRESETn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_sel = 3'd0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        load_DMAC_C0_Addr = 1'b0;
    logic        src_addr_inc = 1'b0;
    logic        dest_addr_inc = 1'b0;
    logic        TransferSize_dec_flag = 1'b0;
    logic        src_burst_zero_flag = 1'b0;
    logic        dest_burst_zero_flag = 1'b0;
    logic        buffer_zero_flag = 1'b0;
    logic        buffer_idx_inc = 1'b0;
    logic        load_fir_src_img = 1'b0;
    logic        CHANNEL_dis_flag = 1'b0;
    logic        set_DMACINTR_status = 1'b0;
    logic [31:0] m_HRDATA = '0;
    logic [31:0] m_HWDATA;
    logic [31:0] DMAC_C0_SrcAddr_Master;
    logic [31:0] DMAC_C0_DestAddr_Master;
    logic [11:0] TS;
    logic [2:0]  BS;
    logic        CHANNEL_enable;
    logic        DMAC_Configuration;
    logic [4:0]  src_burst_cnt;
    logic [4:0]  dest_burst_cnt;
    logic [3:0]  dmac_buffer_idx;
    logic        DMACINTR_mask;
    logic        DMACINTR_pend;
    logic        DMACINTR;

    int checks = 0;
    int failures = 0;

    dmac_ch0_datapath dut (
        .m_HCLK(m_HCLK), .m_HRESETn(m_HRESETn),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .load_DMAC_C0_Addr(load_DMAC_C0_Addr), .src_addr_inc(src_addr_inc),
        .dest_addr_inc(dest_addr_inc), .TransferSize_dec_flag(TransferSize_dec_flag),
        .src_burst_zero_flag(src_burst_zero_flag), .dest_burst_zero_flag(dest_burst_zero_flag),
        .buffer_zero_flag(buffer_zero_flag), .buffer_idx_inc(buffer_idx_inc),
        .load_fir_src_img(load_fir_src_img), .CHANNEL_dis_flag(CHANNEL_dis_flag),
        .set_DMACINTR_status(set_DMACINTR_status), .m_HRDATA(m_HRDATA), .m_HWDATA(m_HWDATA),
        .DMAC_C0_SrcAddr_Master(DMAC_C0_SrcAddr_Master),
        .DMAC_C0_DestAddr_Master(DMAC_C0_DestAddr_Master),
        .TS(TS), .BS(BS), .CHANNEL_enable(CHANNEL_enable),
        .DMAC_Configuration(DMAC_Configuration), .src_burst_cnt(src_burst_cnt),
        .dest_burst_cnt(dest_burst_cnt), .dmac_buffer_idx(dmac_buffer_idx),
        .DMACINTR_mask(DMACINTR_mask), .DMACINTR_pend(DMACINTR_pend), .DMACINTR(DMACINTR)
    );

    always #5 m_HCLK = ~m_HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_HCLK);
        #1;
    endtask

    // Single-cycle CPU write; flags set by the caller ride along in the same cycle.
    task automatic wr(input logic [2:0] sel, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        cfg_sel = sel;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_src",  DMAC_C0_SrcAddr_Master, 32'h0);
        chk("rst_ts",   {20'h0, TS}, 32'h0);
        chk("rst_chen", {31'h0, CHANNEL_enable}, 32'h0);
        chk("rst_hw",   m_HWDATA, 32'h0);
        m_HRESETn = 1'b1;
        tick();

        // Program and run 4 source beats
        wr(3'd0, 32'h1000);
        wr(3'd1, 32'h2000);
        wr(3'd2, 32'h0000_1010);
        chk("ctrl_ts", {20'h0, TS}, 32'd16);
        chk("ctrl_bs", {29'h0, BS}, 32'd1);
        wr(3'd4, 32'h1);
        chk("config", {31'h0, DMAC_Configuration}, 32'h1);
        load_DMAC_C0_Addr = 1'b1; tick(); load_DMAC_C0_Addr = 1'b0;
        chk("load_dest", DMAC_C0_DestAddr_Master, 32'h2000);
        src_addr_inc = 1'b1;
        repeat (4) tick();
        src_addr_inc = 1'b0;
        chk("src_after4", DMAC_C0_SrcAddr_Master, 32'h1010);
        chk("sbc_after4", {27'h0, src_burst_cnt}, 32'd4);
        chk("dest_hold", DMAC_C0_DestAddr_Master, 32'h2000);
        rd("rd_src_prog", 3'd0, 32'h1000);
        dest_addr_inc = 1'b1; tick(); dest_addr_inc = 1'b0;
        chk("dest_inc", DMAC_C0_DestAddr_Master, 32'h2004);
        chk("dbc_inc", {27'h0, dest_burst_cnt}, 32'd1);

        // Buffer fill and replay
        for (int i = 0; i < 4; i++) begin
            m_HRDATA = 32'hA0 + i; load_fir_src_img = 1'b1; buffer_idx_inc = 1'b1;
            tick();
        end
        load_fir_src_img = 1'b0; buffer_idx_inc = 1'b0;
        chk("idx_after_fill", {28'h0, dmac_buffer_idx}, 32'd4);
        buffer_zero_flag = 1'b1; buffer_idx_inc = 1'b1; tick();
        buffer_zero_flag = 1'b0; buffer_idx_inc = 1'b0;
        chk("idx_zero_wins", {28'h0, dmac_buffer_idx}, 32'd0);
        chk("hw0", m_HWDATA, 32'hA0);
        buffer_idx_inc = 1'b1; tick(); chk("hw1", m_HWDATA, 32'hA1);
        tick(); chk("hw2", m_HWDATA, 32'hA2);
        tick(); chk("hw3", m_HWDATA, 32'hA3);
        tick(); buffer_idx_inc = 1'b0;
        m_HRDATA = 32'hB0; load_fir_src_img = 1'b1; tick(); load_fir_src_img = 1'b0;
        chk("load_hold_idx", {28'h0, dmac_buffer_idx}, 32'd4);
        chk("hw_b0", m_HWDATA, 32'hB0);

        // TS countdown, saturation, burst zero priority
        wr(3'd2, 32'h0000_0008);
        TransferSize_dec_flag = 1'b1;
        tick(); chk("ts_4", {20'h0, TS}, 32'd4);
        tick(); chk("ts_0", {20'h0, TS}, 32'd0);
        src_burst_zero_flag = 1'b1; src_addr_inc = 1'b1;
        tick(); chk("ts_floor", {20'h0, TS}, 32'd0);
        chk("sbc_zero_wins", {27'h0, src_burst_cnt}, 32'd0);
        TransferSize_dec_flag = 1'b0; src_burst_zero_flag = 1'b0; src_addr_inc = 1'b0;
        wr(3'd2, 32'h0000_0003);
        rd("rd_ctrl_ts3", 3'd2, 32'h3);
        TransferSize_dec_flag = 1'b1; tick(); TransferSize_dec_flag = 1'b0;
        rd("rd_ctrl_live", 3'd2, 32'h0);

        // Channel enable locks programming
        wr(3'd3, 32'h1);
        wr(3'd0, 32'hFFFF);
        rd("src_locked", 3'd0, 32'h1000);
        rd("status_chen", 3'd7, 32'h4);
        CHANNEL_dis_flag = 1'b1; wr(3'd3, 32'h1); CHANNEL_dis_flag = 1'b0;
        chk("dis_wins", {31'h0, CHANNEL_enable}, 32'h0);

        // Interrupt mask / set / clear
        wr(3'd5, 32'h1);
        set_DMACINTR_status = 1'b1; tick(); set_DMACINTR_status = 1'b0;
        chk("pend_set", {31'h0, DMACINTR_pend}, 32'h1);
        chk("intr_masked", {31'h0, DMACINTR}, 32'h0);
        wr(3'd5, 32'h0);
        chk("intr_unmasked", {31'h0, DMACINTR}, 32'h1);
        set_DMACINTR_status = 1'b1; wr(3'd6, 32'h1); set_DMACINTR_status = 1'b0;
        chk("set_wins", {31'h0, DMACINTR_pend}, 32'h1);
        rd("status_intr", 3'd7, 32'h3);
        wr(3'd6, 32'h1);
        chk("pend_clr", {31'h0, DMACINTR_pend}, 32'h0);
        rd("rd_intclr", 3'd6, 32'h0);

        // Address wrap, load-over-inc, burst saturation
        wr(3'd0, 32'hFFFF_FFFC);
        load_DMAC_C0_Addr = 1'b1; src_addr_inc = 1'b1; tick(); load_DMAC_C0_Addr = 1'b0;
        chk("load_wins", DMAC_C0_SrcAddr_Master, 32'hFFFF_FFFC);
        tick();
        chk("addr_wrap", DMAC_C0_SrcAddr_Master, 32'h0);
        src_burst_zero_flag = 1'b1; tick(); src_burst_zero_flag = 1'b0;
        repeat (17) tick();
        chk("sbc_sat", {27'h0, src_burst_cnt}, 32'd16);

        // Asynchronous reset mid-burst
        #2;
        m_HRESETn = 1'b0;
        #1;
        chk("arst_src", DMAC_C0_SrcAddr_Master, 32'h0);
        chk("arst_dest", DMAC_C0_DestAddr_Master, 32'h0);
        chk("arst_sbc", {27'h0, src_burst_cnt}, 32'd0);
        chk("arst_idx", {28'h0, dmac_buffer_idx}, 32'd0);
        chk("arst_hw", m_HWDATA, 32'h0);
        chk("arst_cfg", {31'h0, DMAC_Configuration}, 32'h0);
        src_addr_inc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
